// File: rtl/req_ack_initiator.sv
// Requester side of a 4-phase req/ack handshake with per-attempt timeout, bounded retry, and latency capture.
// Define REQ_ACK_INITIATOR_ASSERT_EN to compile in protocol assertions.
module req_ack_initiator #(
  parameter  int unsigned TIMEOUT   = 8,
  parameter  int unsigned MAX_RETRY = 3,
  parameter  int unsigned LAT_W     = 8,
  localparam int unsigned RW        = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1),
  localparam int unsigned TW        = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ack,
  output logic             req,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [RW-1:0]    retries,
  output logic [LAT_W-1:0] latency
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BACKOFF, S_RELEASE} state_e;

  localparam logic [TW-1:0] TMO     = TW'(TIMEOUT);
  localparam logic [RW-1:0] RMAX    = RW'(MAX_RETRY);
  localparam logic [TW-1:0] BO_MIN  = TW'(2);
  localparam logic [31:0]   LAT_MAX = (LAT_W >= 32) ? '1 : ((32'd1 << LAT_W) - 32'd1);

  state_e           state_q;
  logic             req_q, busy_q, done_q, err_q;
  logic [RW-1:0]    retries_q;
  logic [LAT_W-1:0] latency_q;
  logic [TW-1:0]    timer_q, ackcnt_q;
  logic [TW-1:0]    timer_inc, ackcnt_inc;
  logic [LAT_W-1:0] lat_sat;

  always_comb begin
    timer_inc  = timer_q + 1'b1;
    ackcnt_inc = ackcnt_q + 1'b1;
    lat_sat    = (32'(timer_inc) > LAT_MAX) ? '1 : LAT_W'(timer_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      retries_q <= '0;
      latency_q <= '0;
      timer_q   <= '0;
      ackcnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !ack) begin
            retries_q <= '0;
            timer_q   <= '0;
            req_q     <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          // timer_inc is the 1-based count of req-high cycles so far
          timer_q <= timer_inc;
          if (ack) begin
            req_q     <= 1'b0;
            latency_q <= lat_sat;
            ackcnt_q  <= '0;
            state_q   <= S_RELEASE;
          end else if (timer_inc == TMO) begin
            req_q    <= 1'b0;
            timer_q  <= '0;
            ackcnt_q <= '0;
            if (retries_q == RMAX) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_BACKOFF;
            end
          end
        end
        S_BACKOFF: begin
          // elapsed-cycle timer saturates at the minimum backoff length
          if (timer_q < BO_MIN) timer_q <= timer_inc;
          if (ack) begin
            ackcnt_q <= ackcnt_inc;
            if (ackcnt_inc == TMO) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            ackcnt_q <= '0;
            if (timer_inc >= BO_MIN) begin
              retries_q <= retries_q + 1'b1;
              timer_q   <= '0;
              req_q     <= 1'b1;
              state_q   <= S_REQ;
            end
          end
        end
        S_RELEASE: begin
          if (!ack) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            ackcnt_q <= ackcnt_inc;
            if (ackcnt_inc == TMO) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req     = req_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign retries = retries_q;
  assign latency = latency_q;

`ifdef REQ_ACK_INITIATOR_ASSERT_EN
  a_req_rise_ack_low: assert property (@(posedge clk) disable iff (rst)
    $rose(req_q) |-> !$past(ack));
  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    (req_q && !ack && (timer_inc < TMO)) |=> req_q);
  a_req_max_len: assert property (@(posedge clk) disable iff (rst)
    req_q |-> (timer_q < TMO));
  a_done_err_excl: assert property (@(posedge clk) disable iff (rst)
    !(done_q && err_q));
  a_done_pulse: assert property (@(posedge clk) disable iff (rst)
    done_q |=> !done_q);
  a_err_pulse: assert property (@(posedge clk) disable iff (rst)
    err_q |=> !err_q);
  a_idle_no_req: assert property (@(posedge clk) disable iff (rst)
    !busy_q |-> !req_q);
  a_retries_max: assert property (@(posedge clk) disable iff (rst)
    retries_q <= RMAX);
  a_rst_clears_req: assert property (@(posedge clk)
    rst |=> !req_q);
`endif

endmodule

// File: tb/tb_req_ack_initiator.sv
// Scoreboard bench for req_ack_initiator: stimulus queues expected outcomes and req-high lengths, a negedge monitor checks them.
module tb_req_ack_initiator;
  localparam int unsigned TIMEOUT   = 8;
  localparam int unsigned MAX_RETRY = 3;
  localparam int unsigned LAT_W     = 8;
  localparam int unsigned RW        = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             ack = 1'b0;
  logic             req, busy, done, err;
  logic [RW-1:0]    retries;
  logic [LAT_W-1:0] latency;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic             is_err;
    logic [RW-1:0]    retries;
    logic [LAT_W-1:0] lat;
  } exp_t;

  exp_t exp_q[$];
  int   len_q[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;
  bit   prev_req = 1'b0, prev_ack = 1'b0, prev_busy = 1'b0, prev_pulse = 1'b0;
  int   hi_len = 0, lo_len = 0;

  always #5 clk = ~clk;

  req_ack_initiator #(
    .TIMEOUT  (TIMEOUT),
    .MAX_RETRY(MAX_RETRY),
    .LAT_W    (LAT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ack    (ack),
    .req    (req),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .retries(retries),
    .latency(latency)
  );

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic v, input string name);
    int n = 0;
    while (req !== v && n < 60) begin
      tick();
      n++;
    end
    if (req !== v) begin
      checks++;
      errors++;
      $display("FAIL %s: req=%0d, required %0d within 60 cycles", name, req, v);
    end
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s: busy still 1 after 100 cycles, required 0", name);
    end
  endtask

  task automatic issue_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Monitor: outcome scoreboard on done/err, req-high lengths on falling req, protocol rules on rising req.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done || err) begin
        check("pulse_exclusive", done && err, 0);
        check("busy_low_with_pulse", busy, 0);
        check("pulse_one_cycle", prev_pulse, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: done=%0d err=%0d, required no pulse", done, err);
        end else begin
          mon_e = exp_q.pop_front();
          check("outcome_err", err, mon_e.is_err);
          check("retries", retries, mon_e.retries);
          check("latency", latency, mon_e.lat);
        end
      end
      if (req) begin
        if (!prev_req) begin
          check("req_rise_ack_low", prev_ack, 0);
          if (prev_busy) check("backoff_gap_min2", lo_len >= 2, 1);
        end
        hi_len++;
        lo_len = 0;
      end else begin
        if (prev_req) begin
          if (len_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req_run: length %0d, required none", hi_len);
          end else begin
            check("req_high_cycles", hi_len, len_q.pop_front());
          end
        end
        hi_len = 0;
        lo_len++;
      end
      prev_req   = req;
      prev_ack   = ack;
      prev_busy  = busy;
      prev_pulse = done || err;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    check("reset_req", req, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_retries", retries, 0);
    check("reset_latency", latency, 0);

    // normal: ack sampled on 3rd req-high cycle, released 2 cycles later
    tick();
    exp_q.push_back('{1'b0, 2'd0, 8'd3});
    len_q.push_back(3);
    issue_start();
    check("t1_req_after_start", req, 1);
    check("t1_busy", busy, 1);
    tick();
    tick();
    ack = 1'b1;
    tick();
    check("t1_req_drop_on_ack", req, 0);
    tick();
    ack = 1'b0;
    wait_idle("t1_idle", n);
    check("t1_release_cycles", n, 1);

    // no responder: four full timeouts then err
    tick();
    for (int i = 0; i < 4; i++) len_q.push_back(TIMEOUT);
    exp_q.push_back('{1'b1, 2'd3, 8'd3});
    issue_start();
    for (int i = 0; i < 4; i++) begin
      wait_req(1'b1, "t2_attempt_rise");
      check("t2_retries_during_attempt", retries, i);
      wait_req(1'b0, "t2_attempt_fall");
    end
    wait_idle("t2_idle", n);
    check("t2_latency_held", latency, 3);

    // timeout then success on 2nd cycle of attempt 2
    tick();
    len_q.push_back(TIMEOUT);
    len_q.push_back(2);
    exp_q.push_back('{1'b0, 2'd1, 8'd2});
    issue_start();
    wait_req(1'b0, "t3_first_timeout");
    wait_req(1'b1, "t3_retry_rise");
    check("t3_retries_on_retry", retries, 1);
    tick();
    ack = 1'b1;
    tick();
    check("t3_req_drop_on_ack", req, 0);
    ack = 1'b0;
    wait_idle("t3_idle", n);

    // stuck ack, then stale start ignored
    tick();
    len_q.push_back(1);
    exp_q.push_back('{1'b1, 2'd0, 8'd1});
    issue_start();
    ack = 1'b1;
    tick();
    check("t4_req_drop_on_ack", req, 0);
    wait_idle("t4_idle", n);
    check("t4_release_cycles", n, TIMEOUT);
    issue_start();
    tick();
    tick();
    check("t4_stale_start_req", req, 0);
    check("t4_stale_start_busy", busy, 0);
    ack = 1'b0;
    tick();
    tick();
    check("t4_start_not_queued", busy, 0);

    // reset mid-REQ, then a normal transaction
    tick();
    len_q.push_back(3);
    issue_start();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("t5_rst_req", req, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_err", err, 0);
    rst = 1'b0;
    check("t5_rst_retries", retries, 0);
    check("t5_rst_latency", latency, 0);
    tick();
    tick();
    len_q.push_back(2);
    exp_q.push_back('{1'b0, 2'd0, 8'd2});
    issue_start();
    tick();
    ack = 1'b1;
    tick();
    check("t5_req_drop_on_ack", req, 0);
    tick();
    ack = 1'b0;
    wait_idle("t5_idle", n);

    // start held high, responder follows req one cycle later: 3-cycle back-to-back transactions
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      len_q.push_back(1);
      exp_q.push_back('{1'b0, 2'd0, 8'd1});
    end
    start = 1'b1;
    repeat (12) begin
      tick();
      ack = req;
    end
    start = 1'b0;
    ack = 1'b0;
    tick();
    tick();
    check("t6_idle_after", busy, 0);

    tick();
    tick();
    check("outcomes_all_seen", exp_q.size(), 0);
    check("req_runs_all_seen", len_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
